// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered N-input priority encoder with fixed or round-robin
// policy, per-input masking and a valid/ready output stage.
module prio_encoder_rr #(
   parameter int N       = 8,
   parameter bit RR_MODE = 1'b0,
   parameter int W       = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic [N-1:0] mask,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot
);
   logic [W-1:0] ptr, start, cand, g;
   logic [N-1:0] eff;
   logic         load, any;
   always_comb begin
      eff   = req & ~mask;
      load  = !out_valid || out_ready;
      any   = |eff;
      start = RR_MODE ? ptr : W'(N-1);
      cand  = '0;
      g     = '0;
      // Walk from the farthest candidate back to start so the closest set bit wins.
      for (int k = N - 1; k >= 0; k--) begin
         cand = W'((int'(start) - k + N) % N);
         if (eff[cand]) g = cand;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_onehot <= '0;
         ptr        <= W'(N-1);
      end else if (load) begin
         out_valid  <= any;
         out_idx    <= any ? g : '0;
         out_onehot <= any ? (N'(1) << g) : '0;
         if (RR_MODE && any) ptr <= (g == '0) ? W'(N-1) : g - W'(1);
      end
   end
endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb_prio_encoder_rr: scoreboard bench over three instances
// (fixed N=8, round-robin N=4, round-robin N=5) sharing clock and reset.
module tb_prio_encoder_rr;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [63:0] rq[3];
   logic [63:0] mk[3];
   logic        rdy[3];

   logic       v8, v4, v5;
   logic [2:0] i8, i5;
   logic [1:0] i4;
   logic [7:0] o8;
   logic [3:0] o4;
   logic [4:0] o5;

   prio_encoder_rr #(.N(8), .RR_MODE(1'b0)) d8 (
      .clk(clk), .rst(rst), .req(rq[0][7:0]), .mask(mk[0][7:0]), .out_ready(rdy[0]),
      .out_valid(v8), .out_idx(i8), .out_onehot(o8));
   prio_encoder_rr #(.N(4), .RR_MODE(1'b1)) d4 (
      .clk(clk), .rst(rst), .req(rq[1][3:0]), .mask(mk[1][3:0]), .out_ready(rdy[1]),
      .out_valid(v4), .out_idx(i4), .out_onehot(o4));
   prio_encoder_rr #(.N(5), .RR_MODE(1'b1)) d5 (
      .clk(clk), .rst(rst), .req(rq[2][4:0]), .mask(mk[2][4:0]), .out_ready(rdy[2]),
      .out_valid(v5), .out_idx(i5), .out_onehot(o5));

   typedef struct {
      int          d;
      logic        v;
      logic [63:0] idx;
      logic [63:0] oh;
      logic [63:0] ptr;
   } exp_t;
   exp_t sbq[$];

   int nn[3] = '{8, 4, 5};
   bit rr[3] = '{1'b0, 1'b1, 1'b1};

   logic        mv[3];
   int          midx[3];
   int          mptr[3];
   logic [63:0] moh[3];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference search: scan indices start, start-1, ... modulo n.
   function automatic int win(input int n, input logic [63:0] eff, input int s);
      for (int k = 0; k < n; k++)
         if (eff[(s - k + n) % n]) return (s - k + n) % n;
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         mv[d] = 1'b0; midx[d] = 0; moh[d] = '0; mptr[d] = nn[d] - 1;
      end
      sbq.delete();
   endtask

   task automatic compare(input exp_t e);
      case (e.d)
         0: begin
            check("d8_valid", 64'(v8), 64'(e.v));   check("d8_idx", 64'(i8), e.idx);
            check("d8_onehot", 64'(o8), e.oh);      check("d8_ptr", 64'(d8.ptr), e.ptr);
         end
         1: begin
            check("d4_valid", 64'(v4), 64'(e.v));   check("d4_idx", 64'(i4), e.idx);
            check("d4_onehot", 64'(o4), e.oh);      check("d4_ptr", 64'(d4.ptr), e.ptr);
         end
         default: begin
            check("d5_valid", 64'(v5), 64'(e.v));   check("d5_idx", 64'(i5), e.idx);
            check("d5_onehot", 64'(o5), e.oh);      check("d5_ptr", 64'(d5.ptr), e.ptr);
         end
      endcase
   endtask

   // Advance the model with the currently driven inputs, queue the expectations,
   // clock once and compare after the edge.
   task automatic step();
      exp_t        e;
      logic [63:0] eff;
      int          g;
      for (int d = 0; d < 3; d++) begin
         if (!mv[d] || rdy[d]) begin
            eff = rq[d] & ~mk[d] & ((64'd1 << nn[d]) - 64'd1);
            if (eff == '0) begin
               mv[d] = 1'b0; midx[d] = 0; moh[d] = '0;
            end else begin
               g = win(nn[d], eff, rr[d] ? mptr[d] : nn[d] - 1);
               mv[d] = 1'b1; midx[d] = g; moh[d] = 64'd1 << g;
               if (rr[d]) mptr[d] = (g == 0) ? nn[d] - 1 : g - 1;
            end
         end
         e.d = d; e.v = mv[d]; e.idx = 64'(midx[d]); e.oh = moh[d]; e.ptr = 64'(mptr[d]);
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      while (sbq.size() > 0) compare(sbq.pop_front());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int seq4[6] = '{3, 2, 1, 0, 3, 2};
      int alt4[4] = '{0, 2, 0, 2};
      int seq5[4] = '{4, 0, 4, 0};
      for (int d = 0; d < 3; d++) begin
         rq[d] = '0; mk[d] = '0; rdy[d] = 1'b1;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_v8", 64'(v8), 0);     check("rst_i8", 64'(i8), 0);
      check("rst_o8", 64'(o8), 0);     check("rst_v4", 64'(v4), 0);
      check("rst_ptr4", 64'(d4.ptr), 3); check("rst_ptr5", 64'(d5.ptr), 4);

      // fixed priority
      rq[0] = 64'h00; step(); check("fx_idle_v", 64'(v8), 0); check("fx_idle_i", 64'(i8), 0);
      rq[0] = 64'h2C; step(); check("fx_2c_i", 64'(i8), 5); check("fx_2c_oh", 64'(o8), 64'h20);
      rq[0] = 64'h01; step(); check("fx_01_i", 64'(i8), 0); check("fx_01_v", 64'(v8), 1);
      rq[0] = 64'hFF; mk[0] = 64'hC0; step(); check("fx_mask_i", 64'(i8), 5);
      mk[0] = 64'hFF; step(); check("fx_allmask_v", 64'(v8), 0);
      rq[0] = '0; mk[0] = '0;

      // round-robin N=4
      rq[1] = 64'hF;
      for (int i = 0; i < 6; i++) begin step(); check("rr4_seq", 64'(i4), 64'(seq4[i])); end
      rq[1] = 64'h5;
      for (int i = 0; i < 4; i++) begin step(); check("rr4_alt", 64'(i4), 64'(alt4[i])); end
      rq[1] = '0; step();

      // round-robin N=5, wrap must land on 4
      rq[2] = 64'h11;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rr5_seq", 64'(i5), 64'(seq5[i]));
         check("rr5_ptr_range", 64'(d5.ptr <= 3'd4), 1);
      end
      rq[2] = '0; step();

      // back-pressure
      do_reset();
      rq[1] = 64'hF; rdy[1] = 1'b0;
      step(); check("bp_first", 64'(i4), 3);
      repeat (3) begin
         step();
         check("bp_hold_i", 64'(i4), 3); check("bp_hold_v", 64'(v4), 1);
         check("bp_hold_ptr", 64'(d4.ptr), 2);
      end
      rdy[1] = 1'b1; step(); check("bp_next", 64'(i4), 2);

      // asynchronous reset mid-stall
      rdy[1] = 1'b0; step();
      #2 rst = 1'b1;
      #1;
      check("arst_v", 64'(v4), 0); check("arst_oh", 64'(o4), 0); check("arst_ptr", 64'(d4.ptr), 3);
      model_reset();
      @(posedge clk);
      #3 rst = 1'b0;
      rdy[1] = 1'b1; rq[1] = 64'hF;
      step(); check("arst_first", 64'(i4), 3);

      // random traffic on all instances
      repeat (200) begin
         for (int d = 0; d < 3; d++) begin
            rq[d]  = {$urandom, $urandom};
            mk[d]  = {$urandom, $urandom} & {$urandom, $urandom};
            rdy[d] = ($urandom_range(0, 3) != 0);
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered N-input priority encoder with a selectable fixed-priority or round-robin policy, per-input masking and a valid/ready output handshake. It is the next-generation replacement for the 4-input fixed priority encoder. It sits between request sources (interrupt lines, FIFO-not-empty flags) and a downstream consumer that may stall, and it presents one winning index per accepted cycle.

## Interface
- N, 8, number of request inputs; legal range 2..64, power of two not required
- RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin
- W, $clog2(N), derived index width; not overridden by the user
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset; asynchronous, active-high
- req  input  N  request vector; bit i requests index i
- mask  input  N  mask vector; 1 blocks the request on that bit
- out_ready  input  1  consumer accepts the current output
- out_valid  output  1  out_idx/out_onehot hold a valid grant
- out_idx  output  W  binary index of the winning request
- out_onehot  output  N  one-hot form of out_idx; all zeros when out_valid=0

## Operation
- Effective request vector: eff = req & ~mask.
- Load condition: load = !out_valid || out_ready. When load is true, the output register samples eff on the clock edge. When load is false (stall), all outputs and the pointer hold.
- On load with eff == 0: out_valid <= 0, out_idx <= 0, out_onehot <= 0. Outputs are never X, unlike the previous block.
- On load with eff != 0: out_valid <= 1, out_idx <= winner g, out_onehot <= 1<<g.
- Fixed mode (RR_MODE=0): g is the highest set index of eff. The pointer is unused and stays at N-1.
- Round-robin mode (RR_MODE=1): the W-bit pointer ptr names the highest-priority index. The search runs ptr, ptr-1, ..., 0, then wraps to N-1, ..., ptr+1, and g is the first set bit found.
- Pointer update: on a load that grants g, ptr <= (g == 0) ? N-1 : g-1. The pointer is unchanged on loads with eff == 0 and during stalls.
- For non-power-of-two N, ptr only ever takes values 0..N-1. Wrap goes to N-1, not 2^W-1.
- Requests are sampled and are not held by the block. A request that deasserts while the block is stalled is lost unless the source holds it.

## Timing
- Latency: 1 cycle from the req/mask sample edge to the outputs.
- Throughput: one grant per cycle while out_ready=1.
- Handshake: a transfer occurs on the edge where out_valid=1 and out_ready=1. out_valid, out_idx and out_onehot stay stable while out_valid=1 and out_ready=0.
- out_ready may be asserted while out_valid=0; it has no effect.
- The outputs are registers only. There is no combinational path from req, mask or out_ready to any output.
- Reset values: out_valid=0, out_idx=0, out_onehot=0, ptr=N-1. After reset, round-robin mode therefore behaves like fixed mode for the first grant.
- Reset asserted mid-stall drops out_valid immediately (asynchronously), discards the held grant and returns ptr to N-1.
- Sampling resumes on the first rising edge after rst deasserts.
- Simultaneous events: mask and req changing in the same cycle are sampled together. A mask applies only to loads and never revokes a grant already held in the output register.

## Test plan
- Fixed mode, N=8: req=0x00 -> out_valid=0, out_idx=0. Then req=0x2C -> out_idx=5, out_onehot=0x20. Then req=0x01 -> out_idx=0, out_valid=1.
- Fixed mode, N=8: req=0xFF, mask=0xC0, out_ready=1 -> out_idx=5. Then mask=0xFF -> out_valid=0 on the next cycle.
- Round-robin mode, N=4: req=0xF held, out_ready=1 -> out_idx sequence 3,2,1,0,3,2. Then req=0x5 -> the grants alternate between 2 and 0.
- Round-robin mode, N=5 (non-power-of-two): req=0x11 held -> out_idx sequence 4,0,4,0. ptr never exceeds 4.
- Back-pressure, round-robin mode, N=4: req=0xF, out_ready=0 for 3 cycles -> out_idx=3 and out_valid=1 stay stable and the pointer holds. When out_ready rises, the next grant is 2.
- Asynchronous reset, round-robin mode, N=4: assert rst mid-stall, between clock edges -> out_valid=0 immediately. After release with req=0xF -> the first grant is 3.
